// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl
//   Streams track bytes from external memory into the 2 KiB double-buffered
//   DAC sample RAM. It primes both halves, starts playback, then refills each
//   half once the DAC has moved off it. It also handles looping, zero-padding
//   and drain at end of track, stop requests and underrun detection.
//
// Ports
//   clkin, reset        system clock, synchronous active-high reset
//   cmd_play, cmd_stop  one-cycle command pulses (stop wins when both arrive)
//   track_start/len     track byte range; a length of 0 only pulses end_of_track
//   loop_en, loop_point loop back to loop_point at end of track
//   dac_half            half currently being played by the DAC
//   mem_req/addr/ack/data  byte read port (req held until the ack pulse)
//   pgm_we_n/address/data  sample RAM write port, address = {half, offset}
//   play, dac_reset     DAC control
//   busy                state is not IDLE
//   underrun            sticky; the DAC left a half while it was being refilled
//   end_of_track        one-cycle pulse when the track ends
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cmd_play
// PRIME0    | filling half 0 before playback starts
// PRIME1    | filling half 1 before playback starts
// RUN       | playing; watching dac_half for a half change
// FILL      | refilling the half the DAC just vacated
// PAD       | writing zeros to the rest of the half after the last byte
// DRAIN     | waiting two half changes so the padded data plays out
// STOPPING  | stop requested with a read in flight; waiting for its ack

module dac_stream_ctrl #(
  parameter int HALF_BYTES = 1024
) (
  input  logic        clkin,
  input  logic        reset,
  input  logic        cmd_play,
  input  logic        cmd_stop,
  input  logic [23:0] track_start,
  input  logic [23:0] track_len,
  input  logic        loop_en,
  input  logic [23:0] loop_point,
  input  logic        dac_half,
  output logic        mem_req,
  output logic [23:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        pgm_we_n,
  output logic [10:0] pgm_address,
  output logic [7:0]  pgm_data,
  output logic        play,
  output logic        dac_reset,
  output logic        busy,
  output logic        underrun,
  output logic        end_of_track
);

  localparam logic [9:0] OFS_LAST = 10'(HALF_BYTES - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRIME0   = 3'd1;
  localparam logic [2:0] S_PRIME1   = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_FILL     = 3'd4;
  localparam logic [2:0] S_PAD      = 3'd5;
  localparam logic [2:0] S_DRAIN    = 3'd6;
  localparam logic [2:0] S_STOPPING = 3'd7;

  logic [2:0]  state;
  logic        half;
  logic [9:0]  offset;
  logic [23:0] src;
  logic [23:0] remaining;
  logic [23:0] loop_len;
  logic        last_half;
  logic        drain_seen;

  logic        flip;
  logic        track_done;
  logic        do_loop;
  logic        half_done;

  always_comb begin
    flip       = dac_half ^ last_half;
    // the byte being acknowledged is the last one of the track
    track_done = (remaining == 24'd1);
    // a zero loop length would never make progress, so treat it as no loop
    do_loop    = loop_en && (loop_len != 24'd0);
    half_done  = (offset == OFS_LAST);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clkin) begin
    if (reset) begin
      state        <= S_IDLE;
      half         <= 1'b0;
      offset       <= '0;
      src          <= '0;
      remaining    <= '0;
      loop_len     <= '0;
      last_half    <= 1'b0;
      drain_seen   <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      pgm_we_n     <= 1'b1;
      pgm_address  <= '0;
      pgm_data     <= '0;
      play         <= 1'b0;
      dac_reset    <= 1'b0;
      underrun     <= 1'b0;
      end_of_track <= 1'b0;
    end else begin
      dac_reset    <= 1'b0;
      end_of_track <= 1'b0;
      pgm_we_n     <= 1'b1;
      last_half    <= dac_half;

      if ((state != S_IDLE) && cmd_stop) begin
        play <= 1'b0;
        // an outstanding read must be retired before the port is released;
        // an ack arriving together with the stop retires it right away
        if (mem_req && !mem_ack) begin
          state <= S_STOPPING;
        end else begin
          mem_req <= 1'b0;
          state   <= S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_play && !cmd_stop) begin
              loop_len <= track_start + track_len - loop_point;
              if (track_len == 24'd0) begin
                end_of_track <= 1'b1;
              end else begin
                dac_reset <= 1'b1;
                underrun  <= 1'b0;
                src       <= track_start;
                remaining <= track_len;
                half      <= 1'b0;
                offset    <= '0;
                state     <= S_PRIME0;
              end
            end
          end

          S_PRIME0, S_PRIME1, S_FILL: begin
            if ((state == S_FILL) && flip) begin
              underrun <= 1'b1;
            end
            if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_addr <= src;
            end else if (mem_ack) begin
              mem_req     <= 1'b0;
              pgm_we_n    <= 1'b0;
              pgm_data    <= mem_data;
              pgm_address <= {half, offset};
              offset      <= offset + 10'd1;
              src         <= src + 24'd1;
              remaining   <= remaining - 24'd1;
              if (track_done && do_loop) begin
                src       <= loop_point;
                remaining <= loop_len;
              end
              if (track_done && !do_loop) begin
                // nothing left to pad when the track ends exactly on a half
                if (half_done) begin
                  drain_seen <= 1'b0;
                  play       <= 1'b1;
                  state      <= S_DRAIN;
                end else begin
                  state <= S_PAD;
                end
              end else if (half_done) begin
                if (state == S_PRIME0) begin
                  half  <= 1'b1;
                  state <= S_PRIME1;
                end else begin
                  state <= S_RUN;
                end
              end
            end
          end

          S_RUN: begin
            // entering RUN from PRIME1 starts playback one cycle after the
            // last write; from FILL play is already high
            play <= 1'b1;
            if (flip) begin
              half   <= last_half;
              offset <= '0;
              state  <= S_FILL;
            end
          end

          S_PAD: begin
            if (flip) begin
              underrun <= 1'b1;
            end
            pgm_we_n    <= 1'b0;
            pgm_data    <= 8'h00;
            pgm_address <= {half, offset};
            offset      <= offset + 10'd1;
            if (half_done) begin
              drain_seen <= 1'b0;
              play       <= 1'b1;
              state      <= S_DRAIN;
            end
          end

          S_DRAIN: begin
            if (flip) begin
              if (drain_seen) begin
                play         <= 1'b0;
                end_of_track <= 1'b1;
                state        <= S_IDLE;
              end else begin
                drain_seen <= 1'b1;
              end
            end
          end

          S_STOPPING: begin
            // the late data is dropped, nothing is written
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= S_IDLE;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb_dac_stream_ctrl
//   Directed bench for dac_stream_ctrl. A memory model answers reads with a
//   byte derived from the address; every sample RAM write and every
//   acknowledged read address is captured for comparison against
//   hand-derived expectations.

module tb_dac_stream_ctrl;

  logic        clkin = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_play = 1'b0;
  logic        cmd_stop = 1'b0;
  logic [23:0] track_start = '0;
  logic [23:0] track_len = '0;
  logic        loop_en = 1'b0;
  logic [23:0] loop_point = '0;
  logic        dac_half = 1'b0;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        pgm_we_n;
  logic [10:0] pgm_address;
  logic [7:0]  pgm_data;
  logic        play;
  logic        dac_reset;
  logic        busy;
  logic        underrun;
  logic        end_of_track;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int eot_cnt = 0;
  int last_wr_cyc = 0;
  int eot0 = 0;
  int bad = 0;
  int k = 0;
  bit ack_en = 1'b1;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [18:0] wr_q[$];
  logic [23:0] req_q[$];

  localparam logic [63:0] RST_VEC = {14'h0, 1'b0, 24'h0, 1'b1, 11'h0, 8'h0, 5'h0};

  dac_stream_ctrl dut (
    .clkin        (clkin),
    .reset        (reset),
    .cmd_play     (cmd_play),
    .cmd_stop     (cmd_stop),
    .track_start  (track_start),
    .track_len    (track_len),
    .loop_en      (loop_en),
    .loop_point   (loop_point),
    .dac_half     (dac_half),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .pgm_we_n     (pgm_we_n),
    .pgm_address  (pgm_address),
    .pgm_data     (pgm_data),
    .play         (play),
    .dac_reset    (dac_reset),
    .busy         (busy),
    .underrun     (underrun),
    .end_of_track (end_of_track)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc++;

  always @(negedge clkin) begin
    if (!pgm_we_n) begin
      wr_q.push_back({pgm_address, pgm_data});
      last_wr_cyc = cyc;
    end
    if (mem_req && mem_ack) req_q.push_back(mem_addr);
    if (end_of_track) eot_cnt++;
  end

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ {a[10:8], a[15:11]} ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [63:0] out_vec();
    return {14'h0, mem_req, mem_addr, pgm_we_n, pgm_address, pgm_data,
            play, dac_reset, busy, underrun, end_of_track};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // one clock; returns 1 time unit after the edge and plays the memory side
  task automatic tick();
    @(posedge clkin);
    #1;
    mem_ack = 1'b0;
    if (mem_req && ack_en) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = mem_byte(mem_addr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic start_play(input logic [23:0] ts, input logic [23:0] tl,
                            input logic le, input logic [23:0] lp);
    track_start = ts;
    track_len   = tl;
    loop_en     = le;
    loop_point  = lp;
    wr_q.delete();
    req_q.delete();
    tick();
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int j = 0;
    while ((wr_q.size() < n) && (j < budget)) begin
      tick();
      j++;
    end
    chk(tag, 64'(wr_q.size() >= n), 64'd1);
  endtask

  task automatic wait_play(input int budget, input string tag);
    int j = 0;
    while (!play && (j < budget)) begin
      tick();
      j++;
    end
    chk(tag, 64'(play), 64'd1);
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) tick();
    chk("reset_state", out_vec(), RST_VEC);
    reset = 1'b0;
    tick();

    // 4096-byte track, immediate acks
    start_play(24'h000000, 24'd4096, 1'b0, 24'h0);
    chk("t1_dac_reset", 64'(dac_reset), 64'd1);
    chk("t1_req_low", 64'(mem_req), 64'd0);
    tick();
    chk("t1_dac_reset_end", 64'(dac_reset), 64'd0);
    chk("t1_req_rise", 64'(mem_req), 64'd1);
    chk("t1_req_addr", 64'(mem_addr), 64'h000000);
    wait_play(6000, "t1_play");
    chk("t1_play_after_last", 64'(cyc), 64'(last_wr_cyc + 1));
    chk("t1_prime_count", 64'(wr_q.size()), 64'd2048);
    bad = 0;
    for (int i = 0; i < 2048 && i < wr_q.size(); i++)
      if (wr_q[i] !== {11'(i), mem_byte(24'(i))}) bad++;
    chk("t1_prime_data", 64'(bad), 64'd0);
    wr_q.delete();
    req_q.delete();
    dac_half = 1'b1;
    tick();
    chk("t1_fill_entry", 64'(mem_req), 64'd0);
    tick();
    chk("t1_fill_req", 64'(mem_req), 64'd1);
    chk("t1_fill_addr", 64'(mem_addr), 64'h000800);
    wait_writes(1024, 3000, "t1_fill_done");
    repeat (5) tick();
    chk("t1_fill_count", 64'(wr_q.size()), 64'd1024);
    bad = 0;
    for (int i = 0; i < 1024 && i < wr_q.size(); i++)
      if (wr_q[i] !== {11'(i), mem_byte(24'h800 + 24'(i))}) bad++;
    chk("t1_fill_data", 64'(bad), 64'd0);
    chk("t1_no_underrun", 64'(underrun), 64'd0);
    chk("t1_run_play", 64'(play), 64'd1);
    pulse_stop();
    chk("t1_stop_play", 64'(play), 64'd0);
    chk("t1_stop_busy", 64'(busy), 64'd0);

    // 1500-byte track, pad and drain
    eot0 = eot_cnt;
    start_play(24'h002000, 24'd1500, 1'b0, 24'h0);
    wait_writes(2048, 6000, "t2_writes");
    bad = 0;
    for (int i = 0; i < 2048 && i < wr_q.size(); i++)
      if (wr_q[i] !== {11'(i), (i < 1500) ? mem_byte(24'h2000 + 24'(i)) : 8'h00}) bad++;
    chk("t2_pad_data", 64'(bad), 64'd0);
    repeat (3) tick();
    chk("t2_req_count", 64'(req_q.size()), 64'd1500);
    chk("t2_play_forced", 64'(play), 64'd1);
    chk("t2_no_eot_yet", 64'(eot_cnt - eot0), 64'd0);
    dac_half = ~dac_half;
    repeat (3) tick();
    chk("t2_drain_busy", 64'(busy), 64'd1);
    chk("t2_drain_play", 64'(play), 64'd1);
    dac_half = ~dac_half;
    tick();
    chk("t2_eot_pulse", 64'(end_of_track), 64'd1);
    chk("t2_eot_play", 64'(play), 64'd0);
    chk("t2_eot_busy", 64'(busy), 64'd0);
    tick();
    chk("t2_eot_single", 64'(end_of_track), 64'd0);
    tick();
    chk("t2_eot_count", 64'(eot_cnt - eot0), 64'd1);

    // looping track, then reset in the middle of a fill
    eot0 = eot_cnt;
    start_play(24'h001000, 24'h000600, 1'b1, 24'h001200);
    wait_writes(2048, 6000, "t3_writes");
    chk("t3_last_before_loop", 64'(req_q[1535]), 64'h0015FF);
    chk("t3_loop_addr", 64'(req_q[1536]), 64'h001200);
    chk("t3_prime_end_addr", 64'(req_q[2047]), 64'h0013FF);
    chk("t3_loop_data", 64'(wr_q[1536]), 64'({11'h600, mem_byte(24'h001200)}));
    wait_play(50, "t3_play");
    wr_q.delete();
    req_q.delete();
    dac_half = ~dac_half;
    wait_writes(600, 3000, "t3_fill");
    chk("t3_fill_start", 64'(req_q[0]), 64'h001400);
    chk("t3_fill_loop", 64'(req_q[512]), 64'h001200);
    chk("t3_no_eot", 64'(eot_cnt - eot0), 64'd0);
    reset = 1'b1;
    tick();
    chk("t3_reset_midop", out_vec(), RST_VEC);
    reset = 1'b0;
    tick();
    chk("t3_reset_idle", 64'(busy), 64'd0);

    // slow ack during fill: underrun, then stop with a read in flight
    dac_half = 1'b0;
    tick();
    start_play(24'h000000, 24'd4096, 1'b0, 24'h0);
    wait_play(6000, "t4_play");
    ack_en = 1'b0;
    wr_q.delete();
    dac_half = 1'b1;
    tick();
    tick();
    chk("t4_fill_req", 64'(mem_req), 64'd1);
    repeat (10) tick();
    dac_half = 1'b0;
    tick();
    chk("t4_underrun_set", 64'(underrun), 64'd1);
    chk("t4_fill_kept", 64'(mem_req), 64'd1);
    repeat (2000) tick();
    mem_ack  = 1'b1;
    mem_data = mem_byte(mem_addr);
    tick();
    tick();
    chk("t4_slow_write_cnt", 64'(wr_q.size()), 64'd1);
    chk("t4_slow_write", 64'(wr_q[0]), 64'({11'h000, mem_byte(24'h000800)}));
    chk("t4_next_addr", 64'(mem_addr), 64'h000801);
    chk("t4_underrun_held", 64'(underrun), 64'd1);
    pulse_stop();
    chk("t5_stop_play", 64'(play), 64'd0);
    chk("t5_stop_busy", 64'(busy), 64'd1);
    chk("t5_stop_req", 64'(mem_req), 64'd1);
    repeat (4) tick();
    mem_ack  = 1'b1;
    mem_data = 8'hA5;
    tick();
    chk("t5_ack_idle", 64'(busy), 64'd0);
    chk("t5_ack_req", 64'(mem_req), 64'd0);
    tick();
    chk("t5_no_write", 64'(wr_q.size()), 64'd1);
    chk("t5_underrun_sticky", 64'(underrun), 64'd1);
    ack_en = 1'b1;
    start_play(24'h000000, 24'd4096, 1'b0, 24'h0);
    chk("t4_underrun_clear", 64'(underrun), 64'd0);
    chk("t4_restart_dac_reset", 64'(dac_reset), 64'd1);
    pulse_stop();
    k = 0;
    while (busy && (k < 50)) begin
      tick();
      k++;
    end
    chk("t4_restart_stopped", 64'(busy), 64'd0);

    // simultaneous play/stop in IDLE, and a zero-length track
    tick();
    track_len = 24'd100;
    cmd_play  = 1'b1;
    cmd_stop  = 1'b1;
    tick();
    cmd_play  = 1'b0;
    cmd_stop  = 1'b0;
    chk("t6_both_dac_reset", 64'(dac_reset), 64'd0);
    chk("t6_both_busy", 64'(busy), 64'd0);
    tick();
    chk("t6_both_req", 64'(mem_req), 64'd0);
    eot0 = eot_cnt;
    track_len = 24'd0;
    cmd_play  = 1'b1;
    tick();
    cmd_play  = 1'b0;
    chk("t6_zero_eot", 64'(end_of_track), 64'd1);
    chk("t6_zero_busy", 64'(busy), 64'd0);
    tick();
    chk("t6_zero_eot_end", 64'(end_of_track), 64'd0);
    tick();
    chk("t6_zero_eot_count", 64'(eot_cnt - eot0), 64'd1);
    chk("t6_zero_no_reset", 64'(dac_reset), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
